instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_if.sv | 25 ++
 rtl/instr_fetch_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory port, decode-side handshake,
// redirect request and fault report. The master is the fetch controller itself.
interface instr_fetch_ctrl_if;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    input  en, imem_instr, out_ready, redirect, redirect_pc,
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc
  );

  modport slave (
    output en, imem_instr, out_ready, redirect, redirect_pc,
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, small in-order fetch buffer,
// redirect handling and a sticky misaligned-target fault state.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_ctrl_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t        state_reg;
  logic [31:0]   pc_reg;
  logic [CW-1:0] count_reg;
  logic          fault_reg;
  logic [31:0]   fault_pc_reg;

  logic pop;
  logic push;
  logic misaligned;

  always_comb begin
    pop        = (count_reg != '0) && bus.out_ready;
    misaligned = |bus.redirect_pc[1:0];
    push       = (state_reg == RUN) && bus.en && !bus.redirect &&
                 ((count_reg < FULL) || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      count_reg    <= '0;
      fault_reg    <= 1'b0;
      fault_pc_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.redirect && misaligned) begin
            state_reg    <= FAULT;
            fault_reg    <= 1'b1;
            fault_pc_reg <= bus.redirect_pc;
          end else begin
            if (bus.redirect) pc_reg <= bus.redirect_pc;
            if (bus.en) state_reg <= RUN;
          end
        end
        RUN: begin
          if (bus.redirect) begin
            // Flush wins over any same-cycle pop; the popped entry is simply consumed.
            count_reg <= '0;
            if (misaligned) begin
              state_reg    <= FAULT;
              fault_reg    <= 1'b1;
              fault_pc_reg <= bus.redirect_pc;
            end else begin
              pc_reg <= bus.redirect_pc;
            end
          end else begin
            if (push) pc_reg <= pc_reg + 32'd4;
            count_reg <= count_reg + CW'(push) - CW'(pop);
          end
        end
        FAULT: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Shift-register buffer: entry 0 is the head, a pop shifts everything down one slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_buf
    logic [31:0] instr_reg;
    logic [31:0] pc_reg;
    logic [31:0] upper_instr;
    logic [31:0] upper_pc;
    logic        load_new;

    if (gi < DEPTH - 1) begin : gen_upper
      assign upper_instr = gen_buf[gi+1].instr_reg;
      assign upper_pc    = gen_buf[gi+1].pc_reg;
    end else begin : gen_top
      assign upper_instr = instr_reg;
      assign upper_pc    = pc_reg;
    end

    assign load_new = push && (pop ? (count_reg == CW'(gi + 1)) : (count_reg == CW'(gi)));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        instr_reg <= '0;
        pc_reg    <= '0;
      end else if (load_new) begin
        instr_reg <= bus.imem_instr;
        pc_reg    <= instr_fetch_ctrl.pc_reg;
      end else if (pop) begin
        instr_reg <= upper_instr;
        pc_reg    <= upper_pc;
      end
    end
  end

  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = (count_reg != '0);
  assign bus.out_instr = gen_buf[0].instr_reg;
  assign bus.out_pc    = gen_buf[0].pc_reg;
  assign bus.fault     = fault_reg;
  assign bus.fault_pc  = fault_pc_reg;

endmodule
